// File: rtl/instr_realign_buffer.sv
// instr_realign_buffer: realigns fetch words into 16/32-bit RV32IC instructions with PCs
module instr_realign_buffer #(
  parameter int FETCH_W = 32,
  parameter int BUF_HW = 8,
  parameter int PC_W = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter bit BYTE_SWAP = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic [PC_W-1:0] flush_pc,
  input  logic fetch_valid,
  output logic fetch_ready,
  input  logic [FETCH_W-1:0] fetch_data,
  output logic instr_valid,
  input  logic instr_ready,
  output logic [31:0] instr,
  output logic [PC_W-1:0] instr_pc,
  output logic instr_is_16,
  output logic [$clog2(BUF_HW):0] occupancy
);
  localparam int NW = FETCH_W / 16;
  localparam int AW = $clog2(BUF_HW);
  localparam int DW = $clog2(FETCH_W / 8) - 1;
  logic [15:0] mem [BUF_HW];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [DW-1:0] drop;
  logic [FETCH_W-1:0] fd;
  logic [15:0] h0, h1;
  logic is32, push, pop;
  logic [AW:0] n_push, n_pop;
  for (genvar l = 0; l < FETCH_W / 32; l++) begin : g_lane
    assign fd[32*l +: 32] = BYTE_SWAP ? {fetch_data[32*l +: 8], fetch_data[32*l+8 +: 8],
                                         fetch_data[32*l+16 +: 8], fetch_data[32*l+24 +: 8]}
                                      : fetch_data[32*l +: 32];
  end
  assign h0 = mem[rd_ptr];
  assign h1 = mem[rd_ptr + AW'(1)];
  assign is32 = h0[1:0] == 2'b11;
  assign instr_valid = is32 ? occupancy >= (AW+1)'(2) : occupancy != '0;
  assign instr = instr_valid ? (is32 ? {h1, h0} : {16'h0, h0}) : '0;
  assign instr_is_16 = instr_valid & ~is32;
  assign fetch_ready = occupancy <= (AW+1)'(BUF_HW - NW);
  assign push = fetch_valid & fetch_ready & ~flush;
  assign pop = instr_valid & instr_ready;
  assign n_push = push ? (AW+1)'(NW) - (AW+1)'(drop) : '0;
  assign n_pop = pop ? (is32 ? (AW+1)'(2) : (AW+1)'(1)) : '0;
  // write the kept halfwords of an accepted fetch word contiguously from wr_ptr
  always_ff @(posedge clk)
    if (push)
      for (int i = 0; i < NW; i++)
        if (i >= int'(drop)) mem[wr_ptr + AW'(i) - AW'(drop)] <= fd[16*i +: 16];
  // pointers, count and PC; flush overrides any push or pop in the same cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      drop <= '0;
      occupancy <= '0;
      instr_pc <= {RESET_PC[PC_W-1:1], 1'b0};
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occupancy <= '0;
      instr_pc <= flush_pc;
      drop <= flush_pc[DW:1];
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(n_push);
        drop <= '0;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(n_pop);
        instr_pc <= instr_pc + (is32 ? PC_W'(4) : PC_W'(2));
      end
      occupancy <= occupancy + n_push - n_pop;
    end
endmodule

// File: tb/tb_instr_realign_buffer.sv
// tb_instr_realign_buffer: directed checks of realignment, straddle, flush, full and reset
module tb_instr_realign_buffer;
  logic clk = 0, rst = 1, flush = 0, fetch_valid = 0, instr_ready = 0;
  logic [31:0] flush_pc = '0, fetch_data = '0;
  logic fetch_ready, instr_valid, instr_is_16;
  logic [31:0] instr, instr_pc;
  logic [3:0] occupancy;
  int errors = 0, checks = 0;
  instr_realign_buffer #(.FETCH_W(32), .BUF_HW(8), .PC_W(32), .RESET_PC(32'h0), .BYTE_SWAP(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .flush_pc(flush_pc), .fetch_valid(fetch_valid),
    .fetch_ready(fetch_ready), .fetch_data(fetch_data), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc), .instr_is_16(instr_is_16),
    .occupancy(occupancy));
  always #5 clk = ~clk;
  task automatic check(string tag, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  function automatic logic [31:0] sw(logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push(logic [31:0] w);
    fetch_valid = 1;
    fetch_data = sw(w);
    step();
    fetch_valid = 0;
  endtask
  task automatic pop();
    instr_ready = 1;
    step();
    instr_ready = 0;
  endtask
  task automatic redirect(logic [31:0] p);
    flush = 1;
    flush_pc = p;
    step();
    flush = 0;
  endtask
  task automatic head(string tag, logic [31:0] i, logic [31:0] pc, logic c16);
    check({tag, "_valid"}, instr_valid, 1);
    check({tag, "_instr"}, instr, i);
    check({tag, "_pc"}, instr_pc, pc);
    check({tag, "_is16"}, instr_is_16, c16);
  endtask
  initial begin
    step();
    step();
    check("rst_valid", instr_valid, 0);
    check("rst_ready", fetch_ready, 1);
    check("rst_occ", occupancy, 0);
    check("rst_instr", instr, 0);
    check("rst_is16", instr_is_16, 0);
    check("rst_pc", instr_pc, 0);
    rst = 0;
    step();
    // T1: single 32-bit instruction
    push(32'h00000513);
    head("t1", 32'h00000513, 0, 0);
    check("t1_occ", occupancy, 2);
    pop();
    check("t1_pc_after", instr_pc, 4);
    check("t1_empty", instr_valid, 0);
    // T2: two compressed instructions in one word
    redirect(0);
    push({16'h4505, 16'h0001});
    head("t2a", 32'h00000001, 0, 1);
    pop();
    head("t2b", 32'h00004505, 2, 1);
    check("t2_occ1", occupancy, 1);
    pop();
    check("t2_occ0", occupancy, 0);
    check("t2_pc", instr_pc, 4);
    // T3: 32-bit add straddling two fetch words
    redirect(0);
    push({16'h0533, 16'h0001});
    head("t3_nop", 32'h00000001, 0, 1);
    instr_ready = 1;
    step();
    for (int k = 0; k < 3; k++) begin
      check("t3_wait_valid", instr_valid, 0);
      check("t3_wait_pc", instr_pc, 2);
      step();
    end
    check("t3_wait_occ", occupancy, 1);
    instr_ready = 0;
    push({16'h0001, 16'h00b5});
    head("t3_add", 32'h00b50533, 2, 0);
    check("t3_occ", occupancy, 3);
    pop();
    head("t3_nop2", 32'h00000001, 6, 1);
    pop();
    check("t3_end_occ", occupancy, 0);
    // T4: misaligned redirect; fetch in the flush cycle is discarded
    flush = 1;
    flush_pc = 32'h102;
    fetch_valid = 1;
    fetch_data = sw(32'h11111111);
    step();
    flush = 0;
    fetch_valid = 0;
    check("t4_flush_occ", occupancy, 0);
    check("t4_flush_valid", instr_valid, 0);
    check("t4_flush_pc", instr_pc, 32'h102);
    push({16'h4505, 16'h0533});
    head("t4", 32'h00004505, 32'h102, 1);
    check("t4_occ", occupancy, 1);
    pop();
    check("t4_pc_after", instr_pc, 32'h104);
    check("t4_empty", occupancy, 0);
    // T5: fill to capacity, reject further pushes, wrap and drain in order
    redirect(0);
    for (int k = 1; k <= 4; k++) push(32'h00000013 | (k << 20));
    check("t5_full_occ", occupancy, 8);
    check("t5_full_ready", fetch_ready, 0);
    push(32'h00900013);
    check("t5_reject_occ", occupancy, 8);
    head("t5_head", 32'h00100013, 0, 0);
    pop();
    check("t5_occ6", occupancy, 6);
    check("t5_ready", fetch_ready, 1);
    push(32'h00500013);
    check("t5_refull", occupancy, 8);
    for (int k = 2; k <= 5; k++) begin
      head("t5_drain", 32'h00000013 | (k << 20), (k - 1) * 4, 0);
      pop();
    end
    check("t5_drained", occupancy, 0);
    check("t5_drained_valid", instr_valid, 0);
    // T6: async reset during simultaneous push and pop
    redirect(0);
    push({16'h0001, 16'h0001});
    check("t6_pre_occ", occupancy, 2);
    fetch_valid = 1;
    fetch_data = sw(32'h45054505);
    instr_ready = 1;
    #2 rst = 1;
    #1;
    check("t6_valid", instr_valid, 0);
    check("t6_occ", occupancy, 0);
    check("t6_ready", fetch_ready, 1);
    check("t6_instr", instr, 0);
    check("t6_pc", instr_pc, 0);
    step();
    fetch_valid = 0;
    instr_ready = 0;
    rst = 0;
    step();
    check("t6_after_occ", occupancy, 0);
    check("t6_after_valid", instr_valid, 0);
    push(32'h00000513);
    head("t6_push", 32'h00000513, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
